// File: rtl/key_debouncer.sv
// Per-key two-flop synchroniser and 4-state debounce FSM producing clean levels and press/release pulses.
// Optional auto-repeat of keys_press while a key is held, enabled by defining KEY_REPEAT_EN.
module key_debouncer #(
  parameter int N_KEYS          = 9,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys_raw,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] keys_press,
  output logic [N_KEYS-1:0] keys_release,
  output logic              any_press
);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_debouncer: illegal parameter combination");
  end

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [1:0]        state_q [N_KEYS];
  logic [1:0]        state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic              any_q;

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD);
  logic [RPT_W-1:0] rpt_q [N_KEYS];
  logic [RPT_W-1:0] rpt_d [N_KEYS];
  logic [RPT_W-1:0] rpt_inc;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
`ifdef KEY_REPEAT_EN
    rpt_inc = '0;
`endif
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef KEY_REPEAT_EN
      rpt_d[i]   = '0;
`endif
      case (state_q[i])
        ST_RELEASED: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_PRESS_WAIT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            // >= lets DEBOUNCE_CYCLES==1 accept on the first cycle in the wait state
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_RELEASE_WAIT;
            cnt_d[i]   = CNT_ONE;
          end else begin
`ifdef KEY_REPEAT_EN
            rpt_inc = rpt_q[i] + 1'b1;
            if (rpt_inc == RPT_NEXT) begin
              rpt_d[i]   = RPT_FIRST;
              press_d[i] = 1'b1;
            end else begin
              rpt_d[i]   = rpt_inc;
              press_d[i] = (rpt_inc == RPT_FIRST);
            end
`endif
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i]   = ST_RELEASED;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_RELEASED;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= '0;
`ifdef KEY_REPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
    end else begin
      sync1_q   <= keys_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= |press_d;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef KEY_REPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  assign keys_level   = level_q;
  assign keys_press   = press_q;
  assign keys_release = release_q;
  assign any_press    = any_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random bouncing input
// compared cycle by cycle against a run-length reference model.
module tb_key_debouncer;
  localparam int N  = 9;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 6;

  logic         sysclk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] keys_raw = '0;
  logic [N-1:0] keys_level, keys_press, keys_release;
  logic         any_press;

  key_debouncer #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(20), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .sysclk(sysclk), .rst(rst), .keys_raw(keys_raw), .keys_level(keys_level),
    .keys_press(keys_press), .keys_release(keys_release), .any_press(any_press)
  );

  always #5 sysclk = ~sysclk;

  int total  = 0;
  int passed = 0;

  // Reference model: synchronised input, accepted level, run length of disagreement, held time.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release;
  int m_run  [N];
  int m_hold [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    for (int i = 0; i < N; i++) begin
      logic s;
      s = m_s2[i];
      m_press[i]   = 1'b0;
      m_release[i] = 1'b0;
      if (s != m_level[i]) begin
        m_run[i]++;
        m_hold[i] = 0;
        if (m_run[i] == D) begin
          m_level[i] = s;
          m_run[i]   = 0;
          if (s) m_press[i] = 1'b1;
          else   m_release[i] = 1'b1;
        end
      end else begin
        if (m_level[i] && m_run[i] == 0) begin
          m_hold[i]++;
`ifdef KEY_REPEAT_EN
          if (m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) m_press[i] = 1'b1;
`endif
        end else begin
          m_hold[i] = 0;
        end
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic step(input logic [N-1:0] raw);
    keys_raw = raw;
    @(posedge sysclk);
    model_edge(raw);
    #1;
    check("level",   keys_level,   m_level);
    check("press",   keys_press,   m_press);
    check("release", keys_release, m_release);
    check("any",     any_press,    |m_press);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_level"},   keys_level,   '0);
    check({tag, "_press"},   keys_press,   '0);
    check({tag, "_release"}, keys_release, '0);
    check({tag, "_any"},     any_press,    '0);
  endtask

  task automatic do_reset(input logic [N-1:0] raw);
    keys_raw = raw;
    @(posedge sysclk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst");
    model_reset();
    @(posedge sysclk);
    @(posedge sysclk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    int acc;
    logic exp_rep;
    model_reset();
    do_reset('0);

    // Single clean press on key 0
    r = '0;
    r[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(r);
      check("t1_press0", keys_press[0], k == 6);
      check("t1_level0", keys_level[0], k >= 6);
      check("t1_any",    any_press,     k == 6);
    end
    for (int k = 0; k < 5; k++) step(r);

    // 3-cycle low glitch while pressed is ignored
    r[0] = 1'b0;
    for (int k = 0; k < 3; k++) step(r);
    r[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(r);
      check("t2_release0", keys_release[0], 1'b0);
      check("t2_level0",   keys_level[0],   1'b1);
    end
    for (int k = 0; k < 74; k++) step(r);

    // Clean release of key 0
    r[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(r);
      check("t3_release0", keys_release[0], k == 6);
      check("t3_level0",   keys_level[0],   k < 6);
    end

    // Simultaneous press of keys 1, 4, 8
    r = 9'h112;
    for (int k = 1; k <= 8; k++) begin
      step(r);
      check("t4_press", keys_press, (k == 6) ? 9'h112 : 9'h000);
    end

    // Key 2 held through reset release
    do_reset(9'h004);
    r = 9'h004;
    for (int k = 1; k <= 8; k++) begin
      step(r);
      check("t5_press", keys_press, (k == 6) ? 9'h004 : 9'h000);
    end

    // Reset while key 5 is mid-debounce
    r = 9'h024;
    for (int k = 0; k < 3; k++) step(r);
    check("t5b_pre_press5", keys_press[5], 1'b0);
    #2 rst = 1'b1;
    #1 check_outputs_zero("t5b_rst");
    model_reset();
    r = '0;
    keys_raw = r;
    @(posedge sysclk);
    #1 rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(r);
      check("t5b_press", keys_press, '0);
    end

    // Hold key 3 and watch for auto-repeat
    r = 9'h008;
    acc = -1;
    for (int k = 1; k <= 20 && acc < 0; k++) begin
      step(r);
      if (keys_press[3]) acc = k;
    end
    check("t6_accept_cycle", acc, 6);
    for (int off = 1; off <= 60; off++) begin
      step(r);
`ifdef KEY_REPEAT_EN
      exp_rep = (off >= RD) && ((off - RD) % RP == 0);
`else
      exp_rep = 1'b0;
`endif
      check("t6_repeat3", keys_press[3], exp_rep);
      check("t6_level3",  keys_level[3], 1'b1);
    end

    // Random bouncing on all keys, checked against the model every cycle
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
      step(r);
      check("rand_excl", keys_press & keys_release, '0);
    end
    r = '0;
    for (int k = 0; k < 10; k++) step(r);
    check("final_level", keys_level, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
